es_stack_ctrl: RTL

ES_STACK_CTRL -- requirements
Module: es_stack_ctrl

---
 rtl/es_stack_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/es_stack_ctrl.sv
// Request sequencer for an external hardware stack: checks capacity, issues one-cycle stack commands, tracks depth.
// Optional ADD op (POP2 then PUSH of the sum) is built when ES_STACK_CTRL_ADD_EN is defined.
`timescale 1ns/1ps
module es_stack_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_arg,
  input  logic [15:0] req_data,
  input  logic [15:0] es_outA,
  input  logic [15:0] es_outB,
  output logic        es_act,
  output logic [1:0]  es_op,
  output logic        es_pop_num,
  output logic [1:0]  es_dup_num,
  output logic [15:0] es_push_val,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        err_clr,
  output logic [5:0]  depth
);

  localparam int unsigned DW      = 16;
  localparam int unsigned DEPTH_W = 6;
  localparam int unsigned CAP     = 32;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_DUP  = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;

  localparam logic [1:0] ES_PUSH = 2'd0;
  localparam logic [1:0] ES_POP  = 2'd1;
  localparam logic [1:0] ES_DUP  = 2'd2;
  localparam logic [1:0] ES_SWAP = 2'd3;

  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_UNF = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
`ifdef ES_STACK_CTRL_ADD_EN
    ISSUE2 = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic               legal_c;
  logic [1:0]         code_c;
  logic               accept_c;
  logic               act_d, pop_d, done_d, ready_d;
  logic [1:0]         op_d, dup_d;
  logic [DW-1:0]      pv_d;

`ifdef ES_STACK_CTRL_ADD_EN
  logic [DW-1:0]      sum_q;
  logic               add_q;
`else
  logic               unused_outs;
  assign unused_outs = ^{es_outA, es_outB};
`endif

  assign accept_c = (state_q == IDLE) && req_valid;

  // Legality of the presented request against the current shadow depth
  always_comb begin
    legal_c = 1'b0;
    code_c  = ERR_ILL;
    case (req_op)
      OP_PUSH: if (depth < DEPTH_W'(CAP)) legal_c = 1'b1; else code_c = ERR_OVF;
      OP_POP:  if (depth >= (req_arg[0] ? 6'd2 : 6'd1)) legal_c = 1'b1; else code_c = ERR_UNF;
      OP_DUP: begin
        if (depth <= DEPTH_W'(req_arg))              code_c  = ERR_UNF;
        else if (depth > 6'd31 - DEPTH_W'(req_arg))  code_c  = ERR_OVF;
        else                                         legal_c = 1'b1;
      end
      OP_SWAP: if (depth >= 6'd2) legal_c = 1'b1; else code_c = ERR_UNF;
`ifdef ES_STACK_CTRL_ADD_EN
      OP_ADD:  if (depth >= 6'd2) legal_c = 1'b1; else code_c = ERR_UNF;
`endif
      default: code_c = ERR_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req_valid) state_d = legal_c ? ISSUE : DONE;
`ifdef ES_STACK_CTRL_ADD_EN
      ISSUE:  state_d = add_q ? ISSUE2 : DONE;
      ISSUE2: state_d = DONE;
`else
      ISSUE:  state_d = DONE;
`endif
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, aligned with the state they belong to
  always_comb begin
    act_d   = 1'b0;
    op_d    = es_op;
    pop_d   = es_pop_num;
    dup_d   = es_dup_num;
    pv_d    = es_push_val;
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
    if (state_q == IDLE && state_d == ISSUE) begin
      act_d = 1'b1;
      case (req_op)
        OP_PUSH: begin op_d = ES_PUSH; pv_d  = req_data;   end
        OP_POP:  begin op_d = ES_POP;  pop_d = req_arg[0]; end
        OP_DUP:  begin op_d = ES_DUP;  dup_d = req_arg;    end
        OP_SWAP: op_d = ES_SWAP;
        OP_ADD:  begin op_d = ES_POP;  pop_d = 1'b1;       end
        default: act_d = 1'b0;
      endcase
    end
`ifdef ES_STACK_CTRL_ADD_EN
    if (state_d == ISSUE2) begin
      act_d = 1'b1;
      op_d  = ES_PUSH;
      pv_d  = sum_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      es_act      <= 1'b0;
      es_op       <= 2'd0;
      es_pop_num  <= 1'b0;
      es_dup_num  <= 2'd0;
      es_push_val <= '0;
      done        <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      es_act      <= act_d;
      es_op       <= op_d;
      es_pop_num  <= pop_d;
      es_dup_num  <= dup_d;
      es_push_val <= pv_d;
      done        <= done_d;
      req_ready   <= ready_d;
    end
  end

`ifdef ES_STACK_CTRL_ADD_EN
  // Sum of the two top words, frozen at accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
      add_q <= 1'b0;
    end else if (accept_c) begin
      sum_q <= es_outA + es_outB;
      add_q <= (req_op == OP_ADD);
    end
  end
`endif

  // Shadow depth follows each issued command at the edge ending its es_act cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) depth <= '0;
    else if (es_act) begin
      case (es_op)
        ES_PUSH: depth <= depth + 6'd1;
        ES_POP:  depth <= depth - (es_pop_num ? 6'd2 : 6'd1);
        ES_DUP:  depth <= depth + DEPTH_W'(es_dup_num) + 6'd1;
        default: depth <= depth;
      endcase
    end
  end

  // Sticky error; a fresh error beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end else if (accept_c && !legal_c) begin
      err      <= 1'b1;
      err_code <= code_c;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end
  end

endmodule
